// File: rtl/fu_grant_arb.sv
// Per-class round-robin grant arbiter for ALU/BRA/LDST/MUL issue requests,
// with multiplier occupancy tracking and load/store back-pressure gating.
module fu_grant_arb #(
  parameter int unsigned REQ_NUM = 4,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [REQ_NUM-1:0] req_alu,
  input  logic [REQ_NUM-1:0] req_bra,
  input  logic [REQ_NUM-1:0] req_ldst,
  input  logic [REQ_NUM-1:0] req_mul,
  input  logic               ldst_ready,
  output logic [REQ_NUM-1:0] grant_alu,
  output logic [REQ_NUM-1:0] grant_bra,
  output logic [REQ_NUM-1:0] grant_ldst,
  output logic [REQ_NUM-1:0] grant_mul,
  output logic               mul_busy,
  output logic               mul_done
);

  localparam int unsigned PtrW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int unsigned CntW = $clog2(MUL_LAT + 1);
  localparam int unsigned NumCls = 4;

  // Class index order: 0 ALU, 1 BRA, 2 LDST, 3 MUL.
  logic [NumCls-1:0][REQ_NUM-1:0] req_all;
  logic [NumCls-1:0][REQ_NUM-1:0] grant_all;
  logic [NumCls-1:0]              cls_ok;
  logic [PtrW-1:0]                ptr_q [NumCls];
  logic [PtrW-1:0]                ptr_d [NumCls];
  logic [CntW-1:0]                cnt_q;
  logic [CntW-1:0]                cnt_d;

  // Lowest request at or above ptr wins; otherwise lowest overall (wrap).
  function automatic logic [REQ_NUM-1:0] rr_pick(input logic [REQ_NUM-1:0] req,
                                                 input logic [PtrW-1:0]    ptr);
    logic [REQ_NUM-1:0] mask;
    logic [REQ_NUM-1:0] hi;
    logic [REQ_NUM-1:0] sel;
    mask = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      mask[i] = (PtrW'(i) >= ptr);
    end
    hi  = req & mask;
    sel = (|hi) ? hi : req;
    return sel & ~(sel - REQ_NUM'(1));
  endfunction

  function automatic logic [PtrW-1:0] ptr_next(input logic [REQ_NUM-1:0] grant,
                                               input logic [PtrW-1:0]    ptr);
    logic [PtrW-1:0] nxt;
    nxt = ptr;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant[i]) begin
        nxt = (i == REQ_NUM - 1) ? '0 : PtrW'(i + 1);
      end
    end
    return nxt;
  endfunction

  assign req_all  = {req_mul, req_ldst, req_bra, req_alu};
  assign mul_busy = (cnt_q > CntW'(1));
  assign mul_done = (cnt_q == CntW'(1));
  assign cls_ok   = {~mul_busy, ldst_ready, 1'b1, 1'b1};

  always_comb begin
    for (int c = 0; c < NumCls; c++) begin
      grant_all[c] = '0;
      if (rst_n && !flush && cls_ok[c]) begin
        grant_all[c] = rr_pick(req_all[c], ptr_q[c]);
      end
      ptr_d[c] = ptr_next(grant_all[c], ptr_q[c]);
    end
  end

  assign grant_alu  = grant_all[0];
  assign grant_bra  = grant_all[1];
  assign grant_ldst = grant_all[2];
  assign grant_mul  = grant_all[3];

  // Reload beats the count-down, so a grant in the mul_done cycle restarts cleanly.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (|grant_mul) begin
      cnt_d = CntW'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int c = 0; c < NumCls; c++) begin
        ptr_q[c] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int c = 0; c < NumCls; c++) begin
        ptr_q[c] <= ptr_d[c];
      end
    end
  end

endmodule

// File: tb/tb_fu_grant_arb.sv
// Directed bench for fu_grant_arb (REQ_NUM=4, MUL_LAT=3) with hand-computed expectations.
module tb_fu_grant_arb;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] req_alu, req_bra, req_ldst, req_mul;
  logic       ldst_ready;
  logic [3:0] grant_alu, grant_bra, grant_ldst, grant_mul;
  logic       mul_busy, mul_done;

  int errors = 0;
  int checks = 0;

  fu_grant_arb #(
    .REQ_NUM(4),
    .MUL_LAT(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_alu   (req_alu),
    .req_bra   (req_bra),
    .req_ldst  (req_ldst),
    .req_mul   (req_mul),
    .ldst_ready(ldst_ready),
    .grant_alu (grant_alu),
    .grant_bra (grant_bra),
    .grant_ldst(grant_ldst),
    .grant_mul (grant_mul),
    .mul_busy  (mul_busy),
    .mul_done  (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow a #1 settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mul(input string tag, input logic [3:0] g, input logic b, input logic d);
    check({tag, ".grant_mul"}, grant_mul, g);
    check({tag, ".mul_busy"}, {3'b0, mul_busy}, {3'b0, b});
    check({tag, ".mul_done"}, {3'b0, mul_done}, {3'b0, d});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [3:0] rr_exp [4];

  initial begin
    rr_exp[0] = 4'b0010;
    rr_exp[1] = 4'b0100;
    rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0001;

    rst_n      = 1'b0;
    flush      = 1'b0;
    ldst_ready = 1'b1;
    req_alu    = 4'b1111;
    req_bra    = 4'b1111;
    req_ldst   = 4'b1111;
    req_mul    = 4'b1111;

    // Reset holds every grant low.
    repeat (3) tick();
    check("rst.grant_alu", grant_alu, 4'b0000);
    check("rst.grant_bra", grant_bra, 4'b0000);
    check("rst.grant_ldst", grant_ldst, 4'b0000);
    chk_mul("rst", 4'b0000, 1'b0, 1'b0);

    // Release: first cycle grants index 0 in every class.
    rst_n = 1'b1;
    #1;
    check("c0.grant_alu", grant_alu, 4'b0001);
    check("c0.grant_bra", grant_bra, 4'b0001);
    check("c0.grant_ldst", grant_ldst, 4'b0001);
    check("c0.grant_mul", grant_mul, 4'b0001);

    // Round robin on ALU and BRA; multiplier grant from c0 counts down alongside.
    tick();
    req_ldst = 4'b0000;
    req_mul  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d.grant_alu", i + 1), grant_alu, rr_exp[i]);
      check($sformatf("rr%0d.grant_bra", i + 1), grant_bra, rr_exp[i]);
      chk_mul($sformatf("rr%0d", i + 1), 4'b0000, (i < 2), (i == 2));
      tick();
    end

    // Sparse wrap: ptr_alu=1, grant index 2, then 0011 wraps to index 0, then index 1.
    req_bra = 4'b0000;
    req_alu = 4'b0100;
    #1;
    check("wrap.idx2", grant_alu, 4'b0100);
    tick();
    req_alu = 4'b0011;
    #1;
    check("wrap.idx0", grant_alu, 4'b0001);
    tick();
    #1;
    check("wrap.idx1", grant_alu, 4'b0010);
    tick();
    req_alu = 4'b0000;

    // LDST back-pressure: ptr_ldst=1 throughout the stall.
    req_ldst   = 4'b0100;
    ldst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("ldst.stall%0d", i), grant_ldst, 4'b0000);
      tick();
    end
    ldst_ready = 1'b1;
    #1;
    check("ldst.ready", grant_ldst, 4'b0100);
    tick();
    req_ldst = 4'b1111;
    #1;
    check("ldst.ptr3", grant_ldst, 4'b1000);
    tick();
    req_ldst = 4'b0000;

    // Asynchronous reset in the middle of a multiply (ptr_mul=1 here).
    req_mul = 4'b1111;
    #1;
    check("amid.grant_mul", grant_mul, 4'b0010);
    tick();
    req_mul = 4'b0000;
    #1;
    chk_mul("amid.busy", 4'b0000, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_mul("amid.rst", 4'b0000, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    #1;
    chk_mul("amid.after", 4'b0000, 1'b0, 1'b0);
    tick();

    // Multiplier occupancy with all pointers back at 0.
    req_mul = 4'b0011;
    #1;
    chk_mul("mul.t0", 4'b0001, 1'b0, 1'b0);
    tick();
    #1;
    chk_mul("mul.t1", 4'b0000, 1'b1, 1'b0);
    tick();
    #1;
    chk_mul("mul.t2", 4'b0000, 1'b1, 1'b0);
    tick();
    #1;
    chk_mul("mul.t3", 4'b0010, 1'b0, 1'b1);
    tick();
    req_mul = 4'b0000;
    #1;
    chk_mul("mul.t4", 4'b0000, 1'b1, 1'b0);
    tick();
    #1;
    chk_mul("mul.t5", 4'b0000, 1'b1, 1'b0);
    tick();
    #1;
    chk_mul("mul.t6", 4'b0000, 1'b0, 1'b1);
    tick();
    #1;
    chk_mul("mul.t7", 4'b0000, 1'b0, 1'b0);
    tick();

    // Flush kills the in-flight multiply and suppresses same-cycle grants (ptr_mul=2).
    req_mul = 4'b0100;
    #1;
    check("fl.t0.grant_mul", grant_mul, 4'b0100);
    tick();
    req_mul = 4'b0000;
    flush   = 1'b1;
    req_alu = 4'b0001;
    req_bra = 4'b0001;
    #1;
    check("fl.t1.grant_alu", grant_alu, 4'b0000);
    check("fl.t1.grant_bra", grant_bra, 4'b0000);
    chk_mul("fl.t1", 4'b0000, 1'b1, 1'b0);
    tick();
    flush   = 1'b0;
    req_alu = 4'b0000;
    req_bra = 4'b0000;
    req_mul = 4'b0001;
    #1;
    chk_mul("fl.t2", 4'b0001, 1'b0, 1'b0);
    tick();
    req_mul = 4'b0000;
    #1;
    chk_mul("fl.t3", 4'b0000, 1'b1, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
